// File: rtl/playbus_pkg.sv
// Shared definitions for the PlayBus address-stepping sequencer: function codes,
// PlayBus controller state encodings and the sequencer state type.
package playbus_pkg;

  typedef enum logic [2:0] {
    F_ROM_RD   = 3'd0,
    F_RAM_RD   = 3'd1,
    F_RAM_WR_S = 3'd2,
    F_ROM_DYN  = 3'd3,
    F_RAM_DYN  = 3'd4,
    F_ROM_LED  = 3'd5,
    F_RAM_WR_D = 3'd6,
    F_RAM_LED  = 3'd7
  } pb_func_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WRITE = 2'd2,
    ST_END   = 2'd3
  } pb_st_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_ADVANCE,
    S_DONE,
    S_ERR
  } seq_state_t;

  // Codes 3..7 need a GO handshake; 0..2 are simply held on the bus.
  function automatic logic is_dynamic(input logic [2:0] func);
    return func >= 3'd3;
  endfunction

endpackage

// File: rtl/pb_run_sync.sv
// Two-flop synchroniser for the asynchronous RUN button plus a rising-edge
// detector fed from a third flop.
module pb_run_sync (
  input  logic CK2HZ,
  input  logic n_CLR,
  input  logic RUN,
  output logic run_sync,
  output logic run_rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = RUN;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign run_sync = sync_q;
  assign run_rise = sync_q & ~prev_q;

endmodule

// File: rtl/playbus_sequencer.sv
// Repeats one PlayBus function over an inclusive, wrapping address range,
// handshaking GO/St for dynamic functions and dwelling for static ones.
module playbus_sequencer
  import playbus_pkg::*;
#(
  parameter int DWELL   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic       CK2HZ,
  input  logic       n_CLR,
  input  logic       RUN,
  input  logic [2:0] MODE,
  input  logic [3:0] START_ADD,
  input  logic [3:0] END_ADD,
  input  logic       HOLD,
  input  logic [1:0] St,
  output logic [2:0] FUNC,
  output logic [3:0] ADD,
  output logic       GO,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [3:0] DWELL_C   = 4'(DWELL);
  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  seq_state_t state_q, state_d;
  logic [2:0] func_q, func_d;
  logic [3:0] add_q, add_d;
  logic [3:0] end_q, end_d;
  logic [3:0] cnt_q, cnt_d;
  logic       go_q, go_d;
  logic       run_sync, run_rise;
  logic [3:0] cnt_inc;

  pb_run_sync u_run_sync (
    .CK2HZ    (CK2HZ),
    .n_CLR    (n_CLR),
    .RUN      (RUN),
    .run_sync (run_sync),
    .run_rise (run_rise)
  );

  assign cnt_inc = cnt_q + 4'd1;

  // The single counter times the dwell for static codes and the St==3 timeout
  // for dynamic ones; it restarts on every entry to ISSUE.
  always_comb begin
    state_d = state_q;
    func_d  = func_q;
    add_d   = add_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          func_d  = MODE;
          add_d   = START_ADD;
          end_d   = END_ADD;
          cnt_d   = 4'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (is_dynamic(func_q)) begin
          if (St == ST_END)             state_d = S_RELEASE;
          else if (cnt_inc == TIMEOUT_C) state_d = S_ERR;
        end else if (cnt_inc == DWELL_C) begin
          state_d = S_ADVANCE;
        end
      end
      S_RELEASE: begin
        if (St == ST_IDLE) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (!HOLD) begin
          if (add_q == end_q) begin
            state_d = S_DONE;
          end else begin
            add_d   = add_q + 4'd1;
            cnt_d   = 4'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (!run_sync) state_d = S_IDLE;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    go_d = (state_d == S_ISSUE) && is_dynamic(func_d);
  end

  always_ff @(posedge CK2HZ or negedge n_CLR) begin
    if (!n_CLR) begin
      state_q <= S_IDLE;
      func_q  <= 3'd0;
      add_q   <= 4'd0;
      end_q   <= 4'd0;
      cnt_q   <= 4'd0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      add_q   <= add_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  assign FUNC = func_q;
  assign ADD  = add_q;
  assign GO   = go_q;
  assign BUSY = (state_q == S_ISSUE) || (state_q == S_RELEASE) || (state_q == S_ADVANCE);
  assign DONE = (state_q == S_DONE);
  assign ERR  = (state_q == S_ERR);

endmodule

// File: tb/tb_playbus_sequencer.sv
// Bench for playbus_sequencer: a run-level reference model plus a responsive
// PlayBus controller model, directed scenarios and randomized runs.
module tb_playbus_sequencer;

  localparam int DWELL   = 4;
  localparam int TIMEOUT = 8;

  logic       ck2hz = 1'b0;
  logic       n_clr = 1'b0;
  logic       run = 1'b0;
  logic       hold = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [3:0] start_add = 4'd0;
  logic [3:0] end_add = 4'd0;
  logic [1:0] st = 2'd0;
  logic [2:0] func;
  logic [3:0] add;
  logic       go, busy, done, err;

  playbus_sequencer #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .CK2HZ     (ck2hz),
    .n_CLR     (n_clr),
    .RUN       (run),
    .MODE      (mode),
    .START_ADD (start_add),
    .END_ADD   (end_add),
    .HOLD      (hold),
    .St        (st),
    .FUNC      (func),
    .ADD       (add),
    .GO        (go),
    .BUSY      (busy),
    .DONE      (done),
    .ERR       (err)
  );

  always #5 ck2hz = ~ck2hz;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the run is described as a list of addresses to visit and a
  // phase inside the current address (0 issuing, 1 releasing, 2 between addresses).
  int       m_act = 0;      // 0 idle, 1 busy, 2 done, 3 err
  int       m_sub = 0;
  int       m_tmr = 0;
  int       m_pos = 0;
  bit       m_dyn = 0;
  int       addr_list[$];
  bit [2:0] e_func = 0;
  bit [3:0] e_add = 0;
  bit       e_go = 0;
  bit       r1 = 0, r2 = 0, r3 = 0;
  bit       rise_now = 0;
  bit       pb_stuck = 0, pb_slow = 0;
  int       cyc = 0;
  int       span = 0;

  task automatic begin_op();
    e_add = 4'(addr_list[m_pos]);
    m_tmr = 0;
    m_sub = 0;
    e_go  = m_dyn;
  endtask

  always begin
    @(posedge ck2hz or negedge n_clr);
    if (!n_clr) begin
      m_act = 0; m_sub = 0; m_tmr = 0; m_pos = 0;
      e_func = 0; e_add = 0; e_go = 0;
      r1 = 0; r2 = 0; r3 = 0;
      st <= 2'd0;
    end else begin
      cyc++;
      rise_now = r2 && !r3;
      case (m_act)
        0: if (rise_now) begin
          addr_list.delete();
          span = (int'(end_add) - int'(start_add) + 16) % 16;
          for (int i = 0; i <= span; i++) addr_list.push_back((int'(start_add) + i) % 16);
          m_dyn  = (mode >= 3);
          e_func = mode;
          m_pos  = 0;
          m_act  = 1;
          begin_op();
        end
        1: begin
          if (m_sub == 0) begin
            m_tmr++;
            if (m_dyn) begin
              if (st == 2'd3) begin m_sub = 1; e_go = 0; end
              else if (m_tmr == TIMEOUT) begin m_act = 3; e_go = 0; end
            end else if (m_tmr == DWELL) begin
              m_sub = 2;
            end
          end else if (m_sub == 1) begin
            if (st == 2'd0) m_sub = 2;
          end else if (!hold) begin
            if (m_pos == addr_list.size() - 1) m_act = 2;
            else begin m_pos++; begin_op(); end
          end
        end
        2: if (!r2) m_act = 0;
        default: ;
      endcase
      // Conforming PlayBus controller, optionally slow or stuck at idle.
      if (pb_stuck) st <= 2'd0;
      else case (st)
        2'd0: if (go) st <= 2'd1;
        2'd1: if (!pb_slow || ($urandom % 3) != 0) st <= 2'd2;
        2'd2: if (!pb_slow || ($urandom % 3) != 0) st <= 2'd3;
        default: if (!go) st <= 2'd0;
      endcase
      r3 = r2; r2 = r1; r1 = run;
    end
  end

  // Per-cycle comparison plus event logging for the directed scenarios.
  int go_rises = 0, busy_rises = 0, busy_cyc = -1, done_cyc = -1, err_cyc = -1;
  int go_cyc[$];
  int go_adds[$];
  int add_log[$];
  bit last_go = 0, last_busy = 0, last_done = 0, last_err = 0;
  bit [3:0] last_add = 0;

  always begin
    @(negedge ck2hz);
    checkOutput("FUNC", int'(func), int'(e_func));
    checkOutput("ADD", int'(add), int'(e_add));
    checkOutput("GO", int'(go), int'(e_go));
    checkOutput("BUSY", int'(busy), int'(m_act == 1));
    checkOutput("DONE", int'(done), int'(m_act == 2));
    checkOutput("ERR", int'(err), int'(m_act == 3));
    if (go && !last_go) begin go_rises++; go_cyc.push_back(cyc); go_adds.push_back(int'(add)); end
    if (busy && !last_busy) begin busy_rises++; busy_cyc = cyc; end
    if (busy && (!last_busy || add != last_add)) add_log.push_back(int'(add));
    if (done && !last_done) done_cyc = cyc;
    if (err && !last_err) err_cyc = cyc;
    last_go = go; last_busy = busy; last_done = done; last_err = err; last_add = add;
  end

  bit rand_hold = 0;
  always begin
    @(posedge ck2hz);
    #1;
    if (rand_hold) hold = (($urandom % 4) == 0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ck2hz);
    #1;
  endtask

  task automatic clear_log();
    go_rises = 0; busy_rises = 0; busy_cyc = -1; done_cyc = -1; err_cyc = -1;
    go_cyc.delete(); go_adds.delete(); add_log.delete();
  endtask

  task automatic applyStimulus(input int m, input int s, input int e);
    mode = 3'(m); start_add = 4'(s); end_add = 4'(e);
    run = 1'b1;
  endtask

  task automatic do_reset();
    #2 n_clr = 1'b0;
    tick(2);
    n_clr = 1'b1;
    tick(1);
  endtask

  task automatic wait_busy(input string name);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ck2hz); #1;
      if (busy) begin ok = 1; break; end
    end
    if (!ok) checkOutput(name, 0, 1);
  endtask

  task automatic wait_end(input string name);
    bit ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge ck2hz); #1;
      if (done || err) begin ok = 1; break; end
    end
    if (!ok) checkOutput(name, 0, 1);
  endtask

  task automatic wait_not_busy(input string name);
    bit ok = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge ck2hz); #1;
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) checkOutput(name, 0, 1);
  endtask

  int exp_t2[4] = '{14, 15, 0, 1};
  int exp_t1[3] = '{2, 3, 4};

  initial begin
    tick(3);
    checkOutput("reset_outputs", int'({func, add, go, busy, done, err}), 0);
    n_clr = 1'b1;
    tick(2);

    // Dynamic run 2..4.
    clear_log();
    applyStimulus(3, 2, 4);
    wait_end("t1_wait");
    tick(1);
    checkOutput("t1_done", int'(done), 1);
    checkOutput("t1_add_held", int'(add), 4);
    checkOutput("t1_go_count", go_rises, 3);
    if (go_adds.size() == 3) begin
      for (int i = 0; i < 3; i++) checkOutput("t1_go_add", go_adds[i], exp_t1[i]);
      checkOutput("t1_addr_period", go_cyc[1] - go_cyc[0], 7);
      checkOutput("t1_done_latency", done_cyc - go_cyc[0], 21);
    end
    run = 1'b0;
    tick(4);

    // Static run wrapping 14..1.
    clear_log();
    applyStimulus(1, 14, 1);
    wait_end("t2_wait");
    tick(1);
    checkOutput("t2_go_count", go_rises, 0);
    checkOutput("t2_addr_count", add_log.size(), 4);
    if (add_log.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput("t2_addr_seq", add_log[i], exp_t2[i]);
    checkOutput("t2_done_latency", done_cyc - busy_cyc, 20);
    run = 1'b0;
    tick(4);

    // Handshake timeout.
    pb_stuck = 1;
    clear_log();
    applyStimulus(5, 0, 3);
    wait_end("t3_wait");
    tick(1);
    checkOutput("t3_err", int'(err), 1);
    checkOutput("t3_go_low", int'(go), 0);
    if (go_cyc.size() > 0) checkOutput("t3_err_latency", err_cyc - go_cyc[0], TIMEOUT);
    else checkOutput("t3_go_seen", 0, 1);
    run = 1'b0;
    tick(6);
    checkOutput("t3_err_sticky", int'(err), 1);
    do_reset();
    pb_stuck = 0;

    // HOLD during the first ADVANCE.
    clear_log();
    applyStimulus(4, 0, 1);
    wait_busy("t4_busy");
    hold = 1'b1;
    run = 1'b0;
    tick(10);
    checkOutput("t4_add_held", int'(add), 0);
    hold = 1'b0;
    wait_end("t4_wait");
    tick(1);
    checkOutput("t4_go_count", go_rises, 2);
    if (go_cyc.size() == 2) begin
      checkOutput("t4_second_add", go_adds[1], 1);
      checkOutput("t4_hold_release", go_cyc[1] - go_cyc[0], 11);
    end
    tick(4);

    // Reset while in RELEASE at address 6.
    clear_log();
    applyStimulus(3, 6, 7);
    wait_busy("t5_busy");
    run = 1'b0;
    tick(4);
    #2 n_clr = 1'b0;
    #1;
    checkOutput("t5_func", int'(func), 0);
    checkOutput("t5_add", int'(add), 0);
    checkOutput("t5_go", int'(go), 0);
    checkOutput("t5_busy", int'(busy), 0);
    tick(2);
    n_clr = 1'b1;
    clear_log();
    tick(20);
    checkOutput("t5_no_restart", go_rises + busy_rises, 0);

    // RUN held through DONE must not retrigger.
    clear_log();
    applyStimulus(2, 3, 3);
    wait_end("t6_wait");
    tick(10);
    checkOutput("t6_done_held", int'(done), 1);
    checkOutput("t6_one_run", busy_rises, 1);
    run = 1'b0;
    tick(5);
    checkOutput("t6_back_idle", int'(done), 0);
    run = 1'b1;
    wait_end("t6_wait2");
    tick(1);
    checkOutput("t6_second_run", busy_rises, 2);
    run = 1'b0;
    tick(5);

    // Randomized runs against the reference model.
    rand_hold = 1;
    for (int n = 0; n < 30; n++) begin
      pb_slow  = ($urandom % 2) == 1;
      pb_stuck = ($urandom % 6) == 0;
      applyStimulus($urandom % 8, $urandom % 16, $urandom % 16);
      tick($urandom_range(1, 30));
      mode = 3'($urandom); start_add = 4'($urandom); end_add = 4'($urandom);
      run = 1'b0;
      if (($urandom % 8) == 0) begin
        tick($urandom_range(1, 20));
        do_reset();
      end
      tick(3);
      wait_not_busy("rand_wait");
      if (err) begin
        tick(2);
        do_reset();
      end
      tick(4);
    end
    rand_hold = 0;
    hold = 1'b0;
    pb_stuck = 0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
